// File: rtl/serial_pkt_framer.sv
// Transmit-side PPP-style framer: FLAG, byte-stuffed payload, optional FCS-16, FLAG.
// Define SERIAL_PKT_FCS_EN to append the complemented CRC-16/X.25 before the closing FLAG.
module serial_pkt_framer #(
    parameter logic [7:0] FLAG     = 8'h7E,
    parameter logic [7:0] ESC      = 8'h7D,
    parameter logic [7:0] XOR_MASK = 8'h20
) (
    input  logic       mclk,
    input  logic       reset_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] tx_data,
    output logic       tx_strobe,
    input  logic       tx_ready,
    output logic       busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SOF,
        S_CHK,
        S_ESC1,
        S_ESC2,
        S_BYTE,
        S_NEXT,
`ifdef SERIAL_PKT_FCS_EN
        S_FCS_LO,
        S_FCS_HI,
`endif
        S_EOF
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] holdData_q, holdData_d;
    logic       holdLast_q, holdLast_d;
    logic [7:0] txData_q, txData_d;
    logic       txStrobe_q, txStrobe_d;
    logic       inReady_q, inReady_d;
    logic       busy_q, busy_d;
    logic       canEmit;
    logic       accept;

`ifdef SERIAL_PKT_FCS_EN
    logic [15:0] fcs_q, fcs_d;
    logic        escPhase_q, escPhase_d;
    logic [7:0]  fcsByte;

    // Reflected CRC-16/X.25 step over one byte, LSB first.
    function automatic logic [15:0] crcUpdate(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ 16'h8408;
            else                c = c >> 1;
        end
        return c;
    endfunction

    assign fcsByte = (state_q == S_FCS_HI) ? ~fcs_q[15:8] : ~fcs_q[7:0];
`endif

    // The gap cycle after every strobe covers the UART's late ready deassert.
    assign canEmit   = tx_ready && !txStrobe_q;
    assign accept    = in_valid && inReady_q;
    assign in_ready  = inReady_q;
    assign tx_data   = txData_q;
    assign tx_strobe = txStrobe_q;
    assign busy      = busy_q;

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            holdData_q <= 8'h00;
            holdLast_q <= 1'b0;
            txData_q   <= 8'h00;
            txStrobe_q <= 1'b0;
            inReady_q  <= 1'b0;
            busy_q     <= 1'b0;
`ifdef SERIAL_PKT_FCS_EN
            fcs_q      <= 16'h0000;
            escPhase_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            holdData_q <= holdData_d;
            holdLast_q <= holdLast_d;
            txData_q   <= txData_d;
            txStrobe_q <= txStrobe_d;
            inReady_q  <= inReady_d;
            busy_q     <= busy_d;
`ifdef SERIAL_PKT_FCS_EN
            fcs_q      <= fcs_d;
            escPhase_q <= escPhase_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        holdData_d = holdData_q;
        holdLast_d = holdLast_q;
        txData_d   = txData_q;
        txStrobe_d = 1'b0;
        busy_d     = busy_q;
`ifdef SERIAL_PKT_FCS_EN
        fcs_d      = fcs_q;
        escPhase_d = escPhase_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    holdData_d = in_data;
                    holdLast_d = in_last;
                    busy_d     = 1'b1;
`ifdef SERIAL_PKT_FCS_EN
                    fcs_d      = 16'hFFFF;
`endif
                    state_d    = S_SOF;
                end
            end
            S_SOF: begin
                if (canEmit) begin
                    txStrobe_d = 1'b1;
                    txData_d   = FLAG;
                    state_d    = S_CHK;
                end
            end
            S_CHK: begin
                state_d = ((holdData_q == FLAG) || (holdData_q == ESC)) ? S_ESC1 : S_BYTE;
            end
            S_ESC1: begin
                if (canEmit) begin
                    txStrobe_d = 1'b1;
                    txData_d   = ESC;
                    state_d    = S_ESC2;
                end
            end
            // The FCS absorbs the unescaped byte on the cycle it leaves for the wire.
            S_ESC2, S_BYTE: begin
                if (canEmit) begin
                    txStrobe_d = 1'b1;
                    txData_d   = (state_q == S_ESC2) ? (holdData_q ^ XOR_MASK) : holdData_q;
`ifdef SERIAL_PKT_FCS_EN
                    fcs_d      = crcUpdate(fcs_q, holdData_q);
`endif
                    state_d    = S_NEXT;
                end
            end
            S_NEXT: begin
                if (holdLast_q) begin
`ifdef SERIAL_PKT_FCS_EN
                    escPhase_d = 1'b0;
                    state_d    = S_FCS_LO;
`else
                    state_d    = S_EOF;
`endif
                end else if (accept) begin
                    holdData_d = in_data;
                    holdLast_d = in_last;
                    state_d    = S_CHK;
                end
            end
`ifdef SERIAL_PKT_FCS_EN
            S_FCS_LO, S_FCS_HI: begin
                if (canEmit) begin
                    txStrobe_d = 1'b1;
                    if (((fcsByte == FLAG) || (fcsByte == ESC)) && !escPhase_q) begin
                        txData_d   = ESC;
                        escPhase_d = 1'b1;
                    end else begin
                        txData_d   = escPhase_q ? (fcsByte ^ XOR_MASK) : fcsByte;
                        escPhase_d = 1'b0;
                        state_d    = (state_q == S_FCS_LO) ? S_FCS_HI : S_EOF;
                    end
                end
            end
`endif
            S_EOF: begin
                if (canEmit) begin
                    txStrobe_d = 1'b1;
                    txData_d   = FLAG;
                    busy_d     = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        inReady_d = (state_d == S_IDLE) || ((state_d == S_NEXT) && !holdLast_d);
    end

endmodule
